// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the demux FIFO slice.
package fifo_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_buf_core.sv
// Circular buffer: in-order storage with wrap-around pointers and occupancy.
module fifo_buf_core
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W     = clog2(DEPTH),
  localparam int unsigned CNT_W     = clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [CNT_W-1:0]      level
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + CNT_W'(1);
      end else if (pop && !push) begin
        level <= level - CNT_W'(1);
      end
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fifo_demux_buf.sv
// Buffered 1-to-N demux: routes buffered words to a channel latched while empty.
module fifo_demux_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_OUT    = 2,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned SEL_W     = clog2(NUM_OUT),
  localparam int unsigned CNT_W     = clog2(DEPTH) + 1
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [DATA_WIDTH-1:0]         fifo_i_din,
  output logic                          fifo_i_full_n,
  input  logic                          fifo_i_write,
  output logic [NUM_OUT*DATA_WIDTH-1:0] fifo_o_din,
  input  logic [NUM_OUT-1:0]            fifo_o_full_n,
  output logic [NUM_OUT-1:0]            fifo_o_write,
  input  logic                          fifo_en,
  input  logic                          drop_mode,
  input  logic [SEL_W-1:0]              sel,
  output logic [CNT_W-1:0]              level,
  output logic [DROP_CNT_W-1:0]         drop_cnt
);

  logic [SEL_W-1:0]      cur_sel;
  logic [DATA_WIDTH-1:0] head;
  logic                  not_empty;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign not_empty = (level != '0);
  assign push      = fifo_i_write & fifo_i_full_n & fifo_en;
  assign pop       = |fifo_o_write;
  assign drop      = fifo_i_write & ~fifo_en & drop_mode;

  // Input readiness; forced low while reset is asserted.
  always_comb begin
    fifo_i_full_n = 1'b0;
    if (fifo_en) begin
      fifo_i_full_n = (level < CNT_W'(DEPTH));
    end else begin
      fifo_i_full_n = drop_mode;
    end
    fifo_i_full_n = fifo_i_full_n & ap_rst_n;
  end

  // Only the latched channel may pop, and only when it has space.
  always_comb begin
    fifo_o_write = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      fifo_o_write[i] = not_empty & (cur_sel == SEL_W'(i)) & fifo_o_full_n[i];
    end
  end

  assign fifo_o_din = {NUM_OUT{head}};

  // Channel select is latched only while empty so a burst never splits.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cur_sel <= '0;
    end else if (!not_empty && (32'(sel) < NUM_OUT)) begin
      cur_sel <= sel;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  fifo_buf_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_i_din),
    .rdata (head),
    .level (level)
  );

endmodule
